// File: rtl/branch_redirect_ctrl.sv
// Next-PC selection and pipeline redirect control for the 5-stage pipeline.
// Latency: control outputs are combinational; counters and stall_err update on the clock edge.
// Backpressure: stall_req freezes PC and IF/ID and inserts an ID/EX bubble; a taken branch overrides it.
module branch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_pc_plus4,
    input  logic             i_branch_ex,
    input  logic             i_branch_taken,
    input  logic [31:0]      i_branch_target,
    input  logic             i_jump_id,
    input  logic [31:0]      i_jump_target,
    input  logic             i_stall_req,
    output logic [31:0]      o_next_pc,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic             o_stall_err
);

    localparam int SW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SHADOW_B = 2'd1,
        SHADOW_J = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_branch_ok;
    logic             w_taken;
    logic             w_jump_ok;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_taken_cnt;
    logic [SW-1:0]    r_stall_run;
    logic             r_stall_err;

    // A branch resolving in the slot right after a taken branch was squashed, so it is ignored.
    // A jump in either shadow cycle came from a flushed fetch slot.
    assign w_branch_ok = i_branch_ex && (r_state != SHADOW_B);
    assign w_taken     = w_branch_ok && i_branch_taken;
    assign w_jump_ok   = i_jump_id && (r_state == RUN);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Event priority: taken branch, then stall (jump held in ID), then jump, then sequential fetch.
    always_comb begin
        w_state_nxt  = RUN;
        o_next_pc    = i_pc_plus4;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        if (i_reset) begin
            o_next_pc    = RESET_PC;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
        end else if (w_taken) begin
            o_next_pc    = i_branch_target;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            w_state_nxt  = SHADOW_B;
        end else if (i_stall_req) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_idex_flush = 1'b1;
        end else if (w_jump_ok) begin
            o_next_pc    = i_jump_target;
            o_ifid_flush = 1'b1;
            w_state_nxt  = SHADOW_J;
        end
    end

    // Saturating counts of honoured branches and of honoured taken branches.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_branch_ok && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_taken && (r_taken_cnt != {CNT_W{1'b1}})) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
        end
    end

    // Stall watchdog: run length of consecutive stall requests; flag is sticky until reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_run <= '0;
            r_stall_err <= 1'b0;
        end else if (i_stall_req) begin
            if (r_stall_run != SW'(MAX_STALL)) begin
                r_stall_run <= r_stall_run + SW'(1);
            end
            if (r_stall_run == SW'(MAX_STALL - 1)) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_stall_run <= '0;
        end
    end

    assign o_branch_cnt = r_branch_cnt;
    assign o_taken_cnt  = r_taken_cnt;
    assign o_stall_err  = r_stall_err;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: vector table plus saturation and watchdog sequences.
// Latency: outputs sampled 1 time unit after inputs change at the falling edge.
// Backpressure: stall behaviour is exercised through stall_req vectors.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_plus4;
    logic        branch_ex;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_id;
    logic [31:0] jump_target;
    logic        stall_req;

    logic [31:0] next_pc, next_pc_s;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s;
    logic [15:0] branch_cnt, taken_cnt;
    logic [1:0]  branch_cnt_s, taken_cnt_s;
    logic        stall_err, stall_err_s;

    int n_cmp = 0;
    int n_err = 0;

    branch_redirect_ctrl #(.RESET_PC(32'h100), .CNT_W(16), .MAX_STALL(8)) dut (
        .i_clk(clk), .i_reset(rst), .i_pc_plus4(pc_plus4),
        .i_branch_ex(branch_ex), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
        .i_jump_id(jump_id), .i_jump_target(jump_target), .i_stall_req(stall_req),
        .o_next_pc(next_pc), .o_pc_write(pc_write), .o_ifid_write(ifid_write),
        .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush),
        .o_branch_cnt(branch_cnt), .o_taken_cnt(taken_cnt), .o_stall_err(stall_err)
    );

    branch_redirect_ctrl #(.RESET_PC(32'h100), .CNT_W(2), .MAX_STALL(8)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_pc_plus4(pc_plus4),
        .i_branch_ex(branch_ex), .i_branch_taken(branch_taken), .i_branch_target(branch_target),
        .i_jump_id(jump_id), .i_jump_target(jump_target), .i_stall_req(stall_req),
        .o_next_pc(next_pc_s), .o_pc_write(pc_write_s), .o_ifid_write(ifid_write_s),
        .o_ifid_flush(ifid_flush_s), .o_idex_flush(idex_flush_s),
        .o_branch_cnt(branch_cnt_s), .o_taken_cnt(taken_cnt_s), .o_stall_err(stall_err_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [31:0] pc4;
        logic        bex;
        logic        btk;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        stl;
        logic [31:0] e_pc;
        logic        e_pw;
        logic        e_iw;
        logic        e_iff;
        logic        e_ief;
        logic [15:0] e_bc;
        logic [15:0] e_tc;
        logic        e_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        pc_plus4      = 32'h0;
        branch_ex     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_id       = 1'b0;
        jump_target   = 32'h0;
        stall_req     = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Counter expectations are the values held before that vector's rising edge.
        //               rst pc4       bex btk btgt      jmp jtgt      stl  e_pc      pw iw iff ief bc     tc     err
        vecs[0]  = '{1'b1, 32'h01C, 0, 0, 32'h000, 0, 32'h000, 0, 32'h100, 0, 0, 1, 1, 16'd0, 16'd0, 0};
        vecs[1]  = '{1'b0, 32'h004, 0, 0, 32'h000, 0, 32'h000, 0, 32'h004, 1, 1, 0, 0, 16'd0, 16'd0, 0};
        vecs[2]  = '{1'b0, 32'h01C, 1, 1, 32'h040, 0, 32'h000, 0, 32'h040, 1, 1, 1, 1, 16'd0, 16'd0, 0};
        vecs[3]  = '{1'b0, 32'h044, 1, 1, 32'h080, 0, 32'h000, 0, 32'h044, 1, 1, 0, 0, 16'd1, 16'd1, 0};
        vecs[4]  = '{1'b0, 32'h048, 1, 0, 32'h000, 0, 32'h000, 0, 32'h048, 1, 1, 0, 0, 16'd1, 16'd1, 0};
        vecs[5]  = '{1'b0, 32'h04C, 0, 0, 32'h000, 1, 32'h200, 0, 32'h200, 1, 1, 1, 0, 16'd2, 16'd1, 0};
        vecs[6]  = '{1'b0, 32'h204, 1, 1, 32'h300, 1, 32'h400, 0, 32'h300, 1, 1, 1, 1, 16'd2, 16'd1, 0};
        vecs[7]  = '{1'b0, 32'h304, 0, 0, 32'h000, 1, 32'h500, 0, 32'h304, 1, 1, 0, 0, 16'd3, 16'd2, 0};
        vecs[8]  = '{1'b0, 32'h308, 0, 0, 32'h000, 1, 32'h600, 1, 32'h308, 0, 0, 0, 1, 16'd3, 16'd2, 0};
        vecs[9]  = '{1'b0, 32'h308, 0, 0, 32'h000, 1, 32'h600, 0, 32'h600, 1, 1, 1, 0, 16'd3, 16'd2, 0};
        vecs[10] = '{1'b0, 32'h604, 1, 1, 32'h700, 0, 32'h000, 1, 32'h700, 1, 1, 1, 1, 16'd3, 16'd2, 0};
        vecs[11] = '{1'b0, 32'h704, 0, 0, 32'h000, 0, 32'h000, 0, 32'h704, 1, 1, 0, 0, 16'd4, 16'd3, 0};
        vecs[12] = '{1'b0, 32'h708, 1, 1, 32'h900, 0, 32'h000, 0, 32'h900, 1, 1, 1, 1, 16'd4, 16'd3, 0};
        vecs[13] = '{1'b1, 32'h904, 1, 1, 32'hA00, 0, 32'h000, 0, 32'h100, 0, 0, 1, 1, 16'd0, 16'd0, 0};
        vecs[14] = '{1'b0, 32'h904, 1, 1, 32'hA00, 0, 32'h000, 0, 32'hA00, 1, 1, 1, 1, 16'd0, 16'd0, 0};
        vecs[15] = '{1'b0, 32'hA04, 0, 0, 32'h000, 0, 32'h000, 0, 32'hA04, 1, 1, 0, 0, 16'd1, 16'd1, 0};

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            pc_plus4      = vecs[i].pc4;
            branch_ex     = vecs[i].bex;
            branch_taken  = vecs[i].btk;
            branch_target = vecs[i].btgt;
            jump_id       = vecs[i].jmp;
            jump_target   = vecs[i].jtgt;
            stall_req     = vecs[i].stl;
            #1;
            chk($sformatf("v%0d next_pc", i),    next_pc,           vecs[i].e_pc);
            chk($sformatf("v%0d pc_write", i),   32'(pc_write),     32'(vecs[i].e_pw));
            chk($sformatf("v%0d ifid_write", i), 32'(ifid_write),   32'(vecs[i].e_iw));
            chk($sformatf("v%0d ifid_flush", i), 32'(ifid_flush),   32'(vecs[i].e_iff));
            chk($sformatf("v%0d idex_flush", i), 32'(idex_flush),   32'(vecs[i].e_ief));
            chk($sformatf("v%0d branch_cnt", i), 32'(branch_cnt),   32'(vecs[i].e_bc));
            chk($sformatf("v%0d taken_cnt", i),  32'(taken_cnt),    32'(vecs[i].e_tc));
            chk($sformatf("v%0d stall_err", i),  32'(stall_err),    32'(vecs[i].e_err));
        end

        // Saturation: five honoured taken branches, each followed by an idle shadow cycle.
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            pc_plus4      = 32'h1000 + 32'(k * 8);
            branch_ex     = 1'b1;
            branch_taken  = 1'b1;
            branch_target = 32'h2000 + 32'(k * 16);
            @(negedge clk);
            clear_inputs();
            @(negedge clk);
        end
        #1;
        chk("sat taken_cnt CNT_W=2",  32'(taken_cnt_s),  32'd3);
        chk("sat branch_cnt CNT_W=2", 32'(branch_cnt_s), 32'd3);
        chk("sat taken_cnt CNT_W=16", 32'(taken_cnt),    32'd5);
        chk("sat branch_cnt CNT_W=16", 32'(branch_cnt),  32'd5);

        // Watchdog: eight consecutive stall cycles set the flag on the eighth edge.
        pulse_reset();
        stall_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("wd pre-edge %0d stall_err", k), 32'(stall_err), 32'd0);
            @(negedge clk);
        end
        #1;
        chk("wd after 8th edge stall_err", 32'(stall_err), 32'd1);
        stall_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("wd sticky stall_err", 32'(stall_err), 32'd1);

        // Watchdog: 7 stalls, one release, 7 stalls never reach the limit.
        pulse_reset();
        #1;
        chk("wd reset clears stall_err", 32'(stall_err), 32'd0);
        stall_req = 1'b1;
        repeat (7) @(negedge clk);
        stall_req = 1'b0;
        @(negedge clk);
        stall_req = 1'b1;
        repeat (7) @(negedge clk);
        stall_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("wd 7+1+7 stall_err", 32'(stall_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
